// File: rtl/load_use_hazard.sv
// rtl/load_use_hazard.sv - load-use hazard detector with aging load-tracking chain
module load_use_hazard #(
    parameter int         INSTR_W  = 16,
    parameter int         REG_W    = 4,
    parameter int         LOAD_LAT = 1,
    parameter int         MODE     = 1,
    parameter logic [3:0] OPC_LW   = 4'b1000,
    parameter logic [3:0] OPC_SW   = 4'b1001,
    parameter int         CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr_id,
    input  logic               id_valid,
    input  logic               flush,
    output logic               stall,
    output logic               load_pending,
    output logic [CNT_W-1:0]   stall_count
);

    // Decode fields of the instruction sitting in ID
    logic [3:0]       opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             is_lw;
    logic             is_sw;

    assign opcode = instr_id[INSTR_W-1 -: 4];
    assign rd     = instr_id[3*REG_W-1 -: REG_W];
    assign rs     = instr_id[2*REG_W-1 -: REG_W];
    assign rt     = instr_id[REG_W-1 -: REG_W];
    assign is_lw  = (opcode == OPC_LW);
    assign is_sw  = (opcode == OPC_SW);

    // Tracking chain: index 0 is the youngest in-flight load
    logic [LOAD_LAT-1:0]            vld_q;
    logic [LOAD_LAT-1:0]            vld_d;
    logic [LOAD_LAT-1:0][REG_W-1:0] dst_q;
    logic [LOAD_LAT-1:0][REG_W-1:0] dst_d;
    logic [CNT_W-1:0]               cnt_q;
    logic [CNT_W-1:0]               cnt_d;
    logic                           hazard;

    // Compare every tracked load against the decode sources; R0 never hazards
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++) begin
            if (vld_q[k]) begin
                if (MODE == 0) begin
                    hazard = 1'b1;
                end else if (dst_q[k] != '0 &&
                             (dst_q[k] == rs || dst_q[k] == rt ||
                              (is_sw && dst_q[k] == rd))) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    // A flushed instruction is dead, so it can neither stall nor be tracked
    assign stall = id_valid && !flush && hazard;

    // Next chain state: capture an issuing load at the head, age everything else
    always_comb begin
        vld_d = '0;
        dst_d = '0;
        if (id_valid && is_lw && !stall && !flush) begin
            vld_d[0] = 1'b1;
            dst_d[0] = rd;
        end
        for (int k = 1; k < LOAD_LAT; k++) begin
            vld_d[k] = vld_q[k-1];
            dst_d[k] = dst_q[k-1];
        end
    end

    // Saturating stall-cycle counter
    always_comb begin
        cnt_d = cnt_q;
        if (stall && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            dst_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            dst_q <= dst_d;
            cnt_q <= cnt_d;
        end
    end

    assign load_pending = |vld_q;
    assign stall_count  = cnt_q;

endmodule

// File: tb/tb_load_use_hazard.sv
// tb/tb_load_use_hazard.sv - directed scoreboard bench for load_use_hazard
module tb_load_use_hazard;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        idv = 1'b0;
    logic        fl = 1'b0;

    logic        a_stall, a_pend;
    logic [15:0] a_cnt;
    logic        b_stall, b_pend;
    logic [15:0] b_cnt;
    logic        c_stall, c_pend;
    logic [15:0] c_cnt;
    logic        d_stall, d_pend;
    logic [1:0]  d_cnt;

    always #5 clk = ~clk;

    load_use_hazard #(.MODE(1), .LOAD_LAT(1)) u_a (
        .clk(clk), .rst(rst), .instr_id(instr), .id_valid(idv), .flush(fl),
        .stall(a_stall), .load_pending(a_pend), .stall_count(a_cnt));
    load_use_hazard #(.MODE(0), .LOAD_LAT(1)) u_b (
        .clk(clk), .rst(rst), .instr_id(instr), .id_valid(idv), .flush(fl),
        .stall(b_stall), .load_pending(b_pend), .stall_count(b_cnt));
    load_use_hazard #(.MODE(1), .LOAD_LAT(2)) u_c (
        .clk(clk), .rst(rst), .instr_id(instr), .id_valid(idv), .flush(fl),
        .stall(c_stall), .load_pending(c_pend), .stall_count(c_cnt));
    load_use_hazard #(.MODE(1), .LOAD_LAT(1), .CNT_W(2)) u_d (
        .clk(clk), .rst(rst), .instr_id(instr), .id_valid(idv), .flush(fl),
        .stall(d_stall), .load_pending(d_pend), .stall_count(d_cnt));

    typedef struct {
        string tag;
        int    sel;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    localparam int A_STALL = 0, A_CNT = 1, A_PEND = 2, B_STALL = 3,
                   C_STALL = 4, C_CNT = 5, D_STALL = 6, D_CNT = 7, D_PEND = 8;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            A_STALL: obs = {31'd0, a_stall};
            A_CNT:   obs = {16'd0, a_cnt};
            A_PEND:  obs = {31'd0, a_pend};
            B_STALL: obs = {31'd0, b_stall};
            C_STALL: obs = {31'd0, c_stall};
            C_CNT:   obs = {16'd0, c_cnt};
            D_STALL: obs = {31'd0, d_stall};
            D_CNT:   obs = {30'd0, d_cnt};
            D_PEND:  obs = {31'd0, d_pend};
            default: obs = 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic expect_v(input string tag, input int sel, input int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel);
            checks++;
            assert (o === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.val);
            end
        end
    endtask

    task automatic step(input logic [15:0] ins, input logic v, input logic f);
        @(negedge clk);
        instr = ins;
        idv   = v;
        fl    = f;
    endtask

    task automatic settle();
        #2;
        drain();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b0;
        idv   = 1'b0;
        fl    = 1'b0;
        instr = 16'h0000;
        #1;
        expect_v("rst_a_cnt", A_CNT, 0);
        expect_v("rst_a_pend", A_PEND, 0);
        expect_v("rst_c_cnt", C_CNT, 0);
        expect_v("rst_d_cnt", D_CNT, 0);
        expect_v("rst_d_pend", D_PEND, 0);
        drain();
        @(negedge clk);
        rst = 1'b1;
    endtask

    int d_stall_pat[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    logic [15:0] d_instr_pat[10] = '{16'h8300, 16'h8330, 16'h8330, 16'h0531, 16'h8300,
                                     16'h0531, 16'h8300, 16'h0531, 16'h8300, 16'h0531};

    initial begin
        int exp_cnt;

        // Reset state, including a dependent-looking instruction while held in reset
        step(16'h0531, 1'b1, 1'b0);
        expect_v("inrst_a_stall", A_STALL, 0);
        expect_v("inrst_a_cnt", A_CNT, 0);
        expect_v("inrst_a_pend", A_PEND, 0);
        expect_v("inrst_b_stall", B_STALL, 0);
        settle();
        do_reset();

        // LW R3 ; ADD R5,R3,R1
        step(16'h8300, 1'b1, 1'b0);
        expect_v("s1_lw_a_stall", A_STALL, 0);
        settle();
        step(16'h0531, 1'b1, 1'b0);
        expect_v("s1_dep_a_stall", A_STALL, 1);
        expect_v("s1_dep_b_stall", B_STALL, 1);
        expect_v("s1_dep_c_stall", C_STALL, 1);
        expect_v("s1_dep_d_stall", D_STALL, 1);
        expect_v("s1_dep_a_pend", A_PEND, 1);
        settle();
        step(16'h0531, 1'b1, 1'b0);
        expect_v("s1_rel_a_stall", A_STALL, 0);
        expect_v("s1_rel_a_cnt", A_CNT, 1);
        expect_v("s1_rel_a_pend", A_PEND, 0);
        expect_v("s1_rel_c_stall", C_STALL, 1);
        settle();
        step(16'h0000, 1'b0, 1'b0);
        expect_v("s1_end_a_stall", A_STALL, 0);
        expect_v("s1_end_a_cnt", A_CNT, 1);
        expect_v("s1_end_c_stall", C_STALL, 0);
        expect_v("s1_end_c_cnt", C_CNT, 2);
        settle();

        // Independent consumer, and R0 loads
        do_reset();
        step(16'h8300, 1'b1, 1'b0);
        expect_v("s2_lw_a_stall", A_STALL, 0);
        settle();
        step(16'h0521, 1'b1, 1'b0);
        expect_v("s2_indep_a_stall", A_STALL, 0);
        expect_v("s2_cons_b_stall", B_STALL, 1);
        settle();
        step(16'h8000, 1'b1, 1'b0);
        expect_v("s2_lwr0_a_stall", A_STALL, 0);
        settle();
        step(16'h0500, 1'b1, 1'b0);
        expect_v("s2_r0_a_stall", A_STALL, 0);
        expect_v("s2_r0_a_pend", A_PEND, 1);
        settle();
        step(16'h0000, 1'b0, 1'b0);
        expect_v("s2_end_a_cnt", A_CNT, 0);
        settle();

        // LOAD_LAT=2: store data register depends on load
        do_reset();
        step(16'h8400, 1'b1, 1'b0);
        expect_v("s3_lw_c_stall", C_STALL, 0);
        settle();
        step(16'h9400, 1'b1, 1'b0);
        expect_v("s3_sw1_c_stall", C_STALL, 1);
        settle();
        step(16'h9400, 1'b1, 1'b0);
        expect_v("s3_sw2_c_stall", C_STALL, 1);
        settle();
        step(16'h9400, 1'b1, 1'b0);
        expect_v("s3_sw3_c_stall", C_STALL, 0);
        expect_v("s3_sw3_c_cnt", C_CNT, 2);
        settle();
        step(16'h8400, 1'b1, 1'b0);
        expect_v("s3_lwb_c_stall", C_STALL, 0);
        settle();
        step(16'h0521, 1'b1, 1'b0);
        expect_v("s3_gap_c_stall", C_STALL, 0);
        settle();
        step(16'h9400, 1'b1, 1'b0);
        expect_v("s3_swb1_c_stall", C_STALL, 1);
        settle();
        step(16'h9400, 1'b1, 1'b0);
        expect_v("s3_swb2_c_stall", C_STALL, 0);
        expect_v("s3_end_c_cnt", C_CNT, 3);
        settle();

        // Flush kills the decode instruction
        do_reset();
        step(16'h8300, 1'b1, 1'b0);
        expect_v("s4_lw_a_stall", A_STALL, 0);
        settle();
        step(16'h0531, 1'b1, 1'b1);
        expect_v("s4_fl_a_stall", A_STALL, 0);
        expect_v("s4_fl_a_pend", A_PEND, 1);
        settle();
        step(16'h8300, 1'b1, 1'b1);
        expect_v("s4_fllw_a_stall", A_STALL, 0);
        expect_v("s4_fllw_a_cnt", A_CNT, 0);
        expect_v("s4_fllw_a_pend", A_PEND, 0);
        settle();
        step(16'h0531, 1'b1, 1'b0);
        expect_v("s4_after_a_stall", A_STALL, 0);
        expect_v("s4_after_a_pend", A_PEND, 0);
        expect_v("s4_after_a_cnt", A_CNT, 0);
        settle();

        // CNT_W=2 saturation, back-to-back loads, reset mid-stall
        do_reset();
        exp_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(d_instr_pat[i], 1'b1, 1'b0);
            expect_v($sformatf("s5_d_stall_%0d", i), D_STALL, d_stall_pat[i]);
            expect_v($sformatf("s5_d_cnt_%0d", i), D_CNT, exp_cnt);
            settle();
            if (d_stall_pat[i] == 1 && exp_cnt < 3) exp_cnt++;
        end
        step(16'h0000, 1'b0, 1'b0);
        expect_v("s5_sat_d_cnt", D_CNT, 3);
        settle();
        step(16'h8300, 1'b1, 1'b0);
        expect_v("s5_lw_d_stall", D_STALL, 0);
        settle();
        step(16'h0531, 1'b1, 1'b0);
        expect_v("s5_pre_d_stall", D_STALL, 1);
        expect_v("s5_pre_d_pend", D_PEND, 1);
        settle();
        #1;
        rst = 1'b0;
        #1;
        expect_v("s5_rst_d_stall", D_STALL, 0);
        expect_v("s5_rst_d_cnt", D_CNT, 0);
        expect_v("s5_rst_d_pend", D_PEND, 0);
        drain();
        @(negedge clk);
        rst = 1'b1;
        step(16'h0531, 1'b1, 1'b0);
        expect_v("s5_post_d_stall", D_STALL, 0);
        expect_v("s5_post_d_cnt", D_CNT, 0);
        settle();
        step(16'h0000, 1'b0, 1'b0);
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_use_hazard.md
LOAD_USE_HAZARD -- requirements
Module: load_use_hazard

Interface
REQ-001 SHALL have parameter INSTR_W, default 16, instruction width.
REQ-002 SHALL have parameter REG_W, default 4, register-specifier width; fields: opcode [INSTR_W-1:INSTR_W-4], rd [3*REG_W-1:2*REG_W], rs [2*REG_W-1:REG_W], rt [REG_W-1:0].
REQ-003 SHALL have parameter LOAD_LAT, default 1, range 1..3, cycles after a load before its data can be forwarded to the next instruction.
REQ-004 SHALL have parameter MODE, default 1; 0 = conservative (stall on any valid instruction following a load), 1 = precise register compare.
REQ-005 SHALL have parameters OPC_LW, default 4'b1000, and OPC_SW, default 4'b1001.
REQ-006 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 instr_id  input  INSTR_W  instruction currently in decode.
REQ-010 id_valid  input  1  instr_id holds a real instruction (not a bubble).
REQ-011 flush  input  1  branch taken in EX; decode instruction is killed this cycle.
REQ-012 stall  output  1  hold PC and IF/ID, insert bubble into ID/EX.
REQ-013 load_pending  output  1  at least one load is being tracked.
REQ-014 stall_count  output  CNT_W  number of stall cycles since reset, saturating.

Function
REQ-015 SHALL hold a tracking shift chain of LOAD_LAT entries, each {valid, dest[REG_W-1:0]}; entry 1 is the youngest.
REQ-016 Each rising edge, entry k SHALL take entry k-1's value (k = 2..LOAD_LAT); the oldest entry is discarded.
REQ-017 Entry 1 SHALL load {1, rd} when id_valid=1, opcode==OPC_LW, stall=0 and flush=0; otherwise {0, 0} (bubble).
REQ-018 Sources of instr_id: rs and rt always; additionally rd when opcode==OPC_SW.
REQ-019 MODE=1: stall SHALL be 1 when id_valid=1, flush=0, and any valid entry has dest != 0 and dest equal to any source; R0 never causes a hazard.
REQ-020 MODE=0: stall SHALL be 1 when id_valid=1, flush=0, and any entry is valid, regardless of registers.
REQ-021 stall SHALL be combinational from instr_id, id_valid, flush and the chain; no additional latency.
REQ-022 flush SHALL override: stall=0 and no entry captured that cycle; entries already in the chain still age normally.
REQ-023 Because a stall inserts a bubble at entry 1, a dependent instruction SHALL stall exactly as many cycles as remain until the matching load leaves the chain (max LOAD_LAT cycles).
REQ-024 load_pending SHALL be the OR of all entry valid bits (registered state, no combinational input path).
REQ-025 stall_count SHALL increment by 1 on each rising edge where stall=1 and hold at 2^CNT_W-1 (no wrap).
REQ-026 Back-to-back loads SHALL be tracked independently; a load whose rd matches an older in-flight load SHALL itself stall when its rs matches.

Reset
REQ-027 rst=0 SHALL asynchronously clear all entries, stall_count=0, load_pending=0; stall then depends only on inputs and SHALL be 0.
REQ-028 Reset asserted mid-stall SHALL drop stall in the same cycle; after release no previously tracked load causes a hazard.

Verification
REQ-029 MODE=1, LAT=1: LW R3 then ADD R5,R3,R1 (rs=3) -> stall=1 for exactly 1 cycle, stall_count=1.
REQ-030 MODE=1, LAT=1: LW R3 then ADD R5,R2,R1 -> stall=0 throughout; LW R0 then ADD R5,R0,R0 -> stall=0.
REQ-031 MODE=0, LAT=1: LW R3 then ADD R5,R2,R1 -> stall=1 for 1 cycle.
REQ-032 MODE=1, LAT=2: LW R4, then SW with rd=4 -> stall=1 for 2 cycles; with one independent instruction between -> stall=1 for 1 cycle.
REQ-033 LW R3 then dependent ADD with flush=1 in the same cycle -> stall=0, entry 1 not captured, stall_count unchanged.
REQ-034 CNT_W=2: hold dependent pattern for 5 stall cycles -> stall_count reads 3 and stays 3; rst=0 mid-stall -> stall=0, stall_count=0, load_pending=0 immediately.
